// File: rtl/qam_pkg.sv
// ============================================================================
// Module      : qam_pkg
// Description : Shared types and helpers for the QAM symbol packer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package qam_pkg;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        IN_PKT = 1'b1
    } packer_state_e;

    function automatic int sym_bits(input int qam_stage);
        return $clog2(qam_stage);
    endfunction

    // Bit offset of a symbol lane inside a packed word.
    function automatic int lane_lsb(input int lane, input int sb);
        return lane * sb;
    endfunction

    function automatic bit widths_legal(input int in_w, input int sb, input int out_w);
        return (sb > 0) && (in_w > 0) && ((in_w % sb) == 0) && ((out_w % in_w) == 0);
    endfunction

endpackage

`default_nettype wire

// File: rtl/qam_st_hold_reg.sv
// ============================================================================
// Module      : qam_st_hold_reg
// Description : Single-entry streaming output register with valid/ready.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module qam_st_hold_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_ready,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data,
    output logic             o_load_ready
);

    logic             r_valid;
    logic [WIDTH-1:0] r_data;

    // A new payload may enter when empty or when the held one leaves this cycle.
    assign o_load_ready = !r_valid || i_ready;
    assign o_valid      = r_valid;
    assign o_data       = r_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
        end else if (r_valid && i_ready) begin
            r_valid <= 1'b0;
        end
    end

endmodule

`default_nettype wire

// File: rtl/qam_symbol_packer.sv
// ============================================================================
// Module      : qam_symbol_packer
// Description : Packs a byte-wide packet stream into words of QAM symbol lanes.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module qam_symbol_packer
    import qam_pkg::*;
#(
    parameter int QAM_STAGE       = 4,
    parameter int PIPELINE_DEEPTH = 16,
    parameter int IN_WIDTH        = 8
) (
    input  logic                                           clock_clk,
    input  logic                                           reset_reset,
    input  logic [IN_WIDTH-1:0]                            asi_in0_data,
    input  logic                                           asi_in0_valid,
    output logic                                           asi_in0_ready,
    input  logic                                           asi_in0_startofpacket,
    input  logic                                           asi_in0_endofpacket,
    output logic [PIPELINE_DEEPTH*sym_bits(QAM_STAGE)-1:0] aso_out0_data,
    output logic                                           aso_out0_valid,
    input  logic                                           aso_out0_ready,
    output logic                                           aso_out0_startofpacket,
    output logic                                           aso_out0_endofpacket,
    output logic [$clog2(PIPELINE_DEEPTH)-1:0]             aso_out0_empty,
    output logic                                           pkt_error
);

    localparam int c_sym_bits = sym_bits(QAM_STAGE);
    localparam int c_out_w    = PIPELINE_DEEPTH * c_sym_bits;
    localparam int c_bpw      = c_out_w / IN_WIDTH;
    localparam int c_spb      = IN_WIDTH / c_sym_bits;
    localparam int c_empty_w  = $clog2(PIPELINE_DEEPTH);
    localparam int c_k_w      = (c_bpw > 1) ? $clog2(c_bpw) : 1;
    localparam int c_pay_w    = c_out_w + 2 + c_empty_w;

    generate
        if (!widths_legal(IN_WIDTH, c_sym_bits, c_out_w)) begin : g_illegal_widths
            $error("qam_symbol_packer: IN_WIDTH must be a multiple of SYM_BITS and divide OUT_W");
        end
    endgenerate

    packer_state_e        r_state, w_state_nxt;
    logic [c_k_w-1:0]     r_k, w_k_nxt, w_k_base;
    logic [c_out_w-1:0]   r_acc, w_acc_nxt, w_word;
    logic                 r_first, w_first_nxt, w_first_base;
    logic                 r_pkt_error;
    logic                 w_accept, w_in_ready, w_load, w_err;
    logic                 w_out_sop, w_out_eop;
    logic [c_empty_w-1:0] w_out_empty;
    logic [c_pay_w-1:0]   w_pay_in, w_pay_out;

    assign w_accept      = asi_in0_valid && w_in_ready;
    assign asi_in0_ready = w_in_ready;
    assign pkt_error     = r_pkt_error;

    always_comb begin
        w_state_nxt  = r_state;
        w_k_nxt      = r_k;
        w_acc_nxt    = r_acc;
        w_first_nxt  = r_first;
        w_k_base     = r_k;
        w_first_base = r_first;
        w_word       = r_acc;
        w_load       = 1'b0;
        w_err        = 1'b0;
        w_out_sop    = 1'b0;
        w_out_eop    = 1'b0;
        w_out_empty  = '0;

        if (w_accept) begin
            if ((r_state == IDLE) && !asi_in0_startofpacket) begin
                // Stray byte outside a packet is consumed and reported.
                w_err = 1'b1;
            end else begin
                if (asi_in0_startofpacket) begin
                    w_err        = (r_state == IN_PKT);
                    w_k_base     = '0;
                    w_first_base = 1'b1;
                    w_word       = '0;
                end
                // Unfilled bytes of the accumulator are always zero, so OR-in suffices.
                w_word = w_word | (c_out_w'(asi_in0_data)
                                   << lane_lsb(int'(w_k_base) * c_spb, c_sym_bits));

                if (asi_in0_endofpacket || (w_k_base == c_k_w'(c_bpw - 1))) begin
                    w_load      = 1'b1;
                    w_out_sop   = w_first_base;
                    w_out_eop   = asi_in0_endofpacket;
                    if (asi_in0_endofpacket) begin
                        w_out_empty = c_empty_w'(PIPELINE_DEEPTH - (int'(w_k_base) + 1) * c_spb);
                    end
                    w_acc_nxt   = '0;
                    w_k_nxt     = '0;
                    w_first_nxt = 1'b0;
                    w_state_nxt = asi_in0_endofpacket ? IDLE : IN_PKT;
                end else begin
                    w_acc_nxt   = w_word;
                    w_k_nxt     = w_k_base + 1'b1;
                    w_first_nxt = w_first_base;
                    w_state_nxt = IN_PKT;
                end
            end
        end
    end

    always_ff @(posedge clock_clk) begin
        if (reset_reset) begin
            r_state     <= IDLE;
            r_k         <= '0;
            r_acc       <= '0;
            r_first     <= 1'b0;
            r_pkt_error <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_k         <= w_k_nxt;
            r_acc       <= w_acc_nxt;
            r_first     <= w_first_nxt;
            r_pkt_error <= w_err;
        end
    end

    assign w_pay_in = {w_word, w_out_sop, w_out_eop, w_out_empty};
    assign {aso_out0_data, aso_out0_startofpacket, aso_out0_endofpacket, aso_out0_empty} = w_pay_out;

    qam_st_hold_reg #(
        .WIDTH (c_pay_w)
    ) u_hold (
        .clk          (clock_clk),
        .rst          (reset_reset),
        .i_load       (w_load),
        .i_data       (w_pay_in),
        .i_ready      (aso_out0_ready),
        .o_valid      (aso_out0_valid),
        .o_data       (w_pay_out),
        .o_load_ready (w_in_ready)
    );

endmodule

`default_nettype wire

// File: tb/tb_qam_symbol_packer.sv
// ============================================================================
// Module      : tb_qam_symbol_packer
// Description : Self-checking bench for qam_symbol_packer (4-QAM, 16 lanes, bytes).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_qam_symbol_packer;

    logic        clock_clk = 1'b0;
    logic        reset_reset;
    logic [7:0]  asi_in0_data;
    logic        asi_in0_valid;
    logic        asi_in0_ready;
    logic        asi_in0_startofpacket;
    logic        asi_in0_endofpacket;
    logic [31:0] aso_out0_data;
    logic        aso_out0_valid;
    logic        aso_out0_ready;
    logic        aso_out0_startofpacket;
    logic        aso_out0_endofpacket;
    logic [3:0]  aso_out0_empty;
    logic        pkt_error;

    typedef struct {
        logic [7:0] d;
        bit         sop;
        bit         eop;
    } beat_t;

    typedef struct {
        logic [31:0] d;
        bit          sop;
        bit          eop;
        logic [3:0]  empty;
        int          cyc;
    } word_t;

    word_t got_q[$];
    int    err_seen   = 0;
    int    cyc        = 0;
    int    compared   = 0;
    int    mismatched = 0;

    qam_symbol_packer #(
        .QAM_STAGE       (4),
        .PIPELINE_DEEPTH (16),
        .IN_WIDTH        (8)
    ) dut (
        .clock_clk              (clock_clk),
        .reset_reset            (reset_reset),
        .asi_in0_data           (asi_in0_data),
        .asi_in0_valid          (asi_in0_valid),
        .asi_in0_ready          (asi_in0_ready),
        .asi_in0_startofpacket  (asi_in0_startofpacket),
        .asi_in0_endofpacket    (asi_in0_endofpacket),
        .aso_out0_data          (aso_out0_data),
        .aso_out0_valid         (aso_out0_valid),
        .aso_out0_ready         (aso_out0_ready),
        .aso_out0_startofpacket (aso_out0_startofpacket),
        .aso_out0_endofpacket   (aso_out0_endofpacket),
        .aso_out0_empty         (aso_out0_empty),
        .pkt_error              (pkt_error)
    );

    always #5 clock_clk = ~clock_clk;

    always @(posedge clock_clk) cyc <= cyc + 1;

    // Output monitor: a transfer is recorded when valid and ready are both seen.
    always @(negedge clock_clk) begin
        if (aso_out0_valid && aso_out0_ready) begin
            got_q.push_back('{aso_out0_data, aso_out0_startofpacket, aso_out0_endofpacket,
                              aso_out0_empty, cyc});
        end
        if (pkt_error) err_seen++;
    end

    function automatic beat_t mk(input logic [7:0] d, input bit sop, input bit eop);
        beat_t b;
        b.d = d; b.sop = sop; b.eop = eop;
        return b;
    endfunction

    // Reference: walk the beat list packet by packet and build the words it should yield.
    task automatic build_expected(input beat_t bq[$], output word_t wq[$], output int errs);
        bit         in_pkt = 0;
        bit         first  = 0;
        logic [7:0] bytes[$];
        word_t      w;
        errs = 0;
        wq.delete();
        foreach (bq[i]) begin
            if (!in_pkt && !bq[i].sop) begin
                errs++;
                continue;
            end
            if (bq[i].sop) begin
                if (in_pkt) errs++;
                bytes.delete();
                first  = 1;
                in_pkt = 1;
            end
            bytes.push_back(bq[i].d);
            if (bytes.size() == 4 || bq[i].eop) begin
                w.d = 32'h0;
                foreach (bytes[j]) w.d = w.d + (32'(bytes[j]) << (8 * j));
                w.sop   = first;
                w.eop   = bq[i].eop;
                w.empty = bq[i].eop ? 4'(16 - 4 * bytes.size()) : 4'd0;
                w.cyc   = 0;
                wq.push_back(w);
                first = 0;
                bytes.delete();
                if (bq[i].eop) in_pkt = 0;
            end
        end
    endtask

    task automatic drive_beats(input beat_t bq[$], output int last_cyc);
        last_cyc = -1;
        foreach (bq[i]) begin
            bit acc   = 0;
            int waits = 0;
            asi_in0_valid         = 1'b1;
            asi_in0_data          = bq[i].d;
            asi_in0_startofpacket = bq[i].sop;
            asi_in0_endofpacket   = bq[i].eop;
            while (!acc) begin
                @(negedge clock_clk);
                if (asi_in0_ready) begin
                    acc      = 1;
                    last_cyc = cyc;
                end
                @(posedge clock_clk); #1;
                waits++;
                if (!acc && waits > 200) begin
                    compared++; mismatched++;
                    $display("FAIL input_timeout: beat %0d not accepted after %0d cycles, required acceptance", i, waits);
                    break;
                end
            end
            if (!acc) break;
        end
        asi_in0_valid         = 1'b0;
        asi_in0_data          = 8'h00;
        asi_in0_startofpacket = 1'b0;
        asi_in0_endofpacket   = 1'b0;
    endtask

    task automatic wait_drain();
        int quiet = 0;
        for (int i = 0; i < 100 && quiet < 4; i++) begin
            @(negedge clock_clk);
            if (!aso_out0_valid) quiet++; else quiet = 0;
        end
        compared++;
        if (quiet < 4) begin
            mismatched++;
            $display("FAIL drain_timeout: output still valid after 100 cycles, required idle");
        end
        @(posedge clock_clk); #1;
    endtask

    task automatic test_reset();
        reset_reset           = 1'b1;
        asi_in0_valid         = 1'b0;
        asi_in0_data          = 8'h00;
        asi_in0_startofpacket = 1'b0;
        asi_in0_endofpacket   = 1'b0;
        aso_out0_ready        = 1'b1;
        repeat (3) @(posedge clock_clk);
        @(negedge clock_clk);
        compared++; if (aso_out0_valid !== 1'b0) begin mismatched++; $display("FAIL reset_valid: got %0b required 0", aso_out0_valid); end
        compared++; if (aso_out0_data !== 32'h0) begin mismatched++; $display("FAIL reset_data: got %h required 00000000", aso_out0_data); end
        compared++; if (aso_out0_startofpacket !== 1'b0) begin mismatched++; $display("FAIL reset_sop: got %0b required 0", aso_out0_startofpacket); end
        compared++; if (aso_out0_endofpacket !== 1'b0) begin mismatched++; $display("FAIL reset_eop: got %0b required 0", aso_out0_endofpacket); end
        compared++; if (aso_out0_empty !== 4'h0) begin mismatched++; $display("FAIL reset_empty: got %0d required 0", aso_out0_empty); end
        compared++; if (pkt_error !== 1'b0) begin mismatched++; $display("FAIL reset_pkt_error: got %0b required 0", pkt_error); end
        compared++; if (asi_in0_ready !== 1'b1) begin mismatched++; $display("FAIL reset_in_ready: got %0b required 1", asi_in0_ready); end
        @(posedge clock_clk); #1;
        reset_reset = 1'b0;
    endtask

    task automatic test_single_word();
        beat_t bq[$];
        word_t w;
        int    lc;
        int    g0 = got_q.size();
        bq.push_back(mk(8'h1B, 1, 0));
        bq.push_back(mk(8'hE4, 0, 0));
        bq.push_back(mk(8'h00, 0, 0));
        bq.push_back(mk(8'hFF, 0, 1));
        drive_beats(bq, lc);
        wait_drain();
        compared++;
        if (got_q.size() - g0 != 1) begin
            mismatched++;
            $display("FAIL single_word_count: got %0d words required 1", got_q.size() - g0);
        end else begin
            w = got_q[g0];
            compared++; if (w.d !== 32'hFF00E41B) begin mismatched++; $display("FAIL single_word_data: got %h required ff00e41b", w.d); end
            compared++; if (w.sop !== 1'b1 || w.eop !== 1'b1) begin mismatched++; $display("FAIL single_word_sop_eop: got %0b/%0b required 1/1", w.sop, w.eop); end
            compared++; if (w.empty !== 4'd0) begin mismatched++; $display("FAIL single_word_empty: got %0d required 0", w.empty); end
            compared++; if (w.d[1:0] !== 2'b11 || w.d[3:2] !== 2'b10) begin mismatched++; $display("FAIL single_word_lanes: got lane0=%b lane1=%b required 11/10", w.d[1:0], w.d[3:2]); end
            compared++; if (w.cyc - lc != 1) begin mismatched++; $display("FAIL single_word_latency: got %0d cycles required 1", w.cyc - lc); end
        end
    endtask

    task automatic test_two_words();
        beat_t bq[$];
        int    lc;
        int    g0 = got_q.size();
        for (int i = 1; i <= 6; i++) bq.push_back(mk(8'(i), i == 1, i == 6));
        drive_beats(bq, lc);
        wait_drain();
        compared++;
        if (got_q.size() - g0 != 2) begin
            mismatched++;
            $display("FAIL two_words_count: got %0d words required 2", got_q.size() - g0);
        end else begin
            compared++; if (got_q[g0].d !== 32'h04030201 || got_q[g0].sop !== 1'b1 || got_q[g0].eop !== 1'b0 || got_q[g0].empty !== 4'd0) begin
                mismatched++; $display("FAIL two_words_w0: got %h sop=%0b eop=%0b empty=%0d required 04030201 1 0 0", got_q[g0].d, got_q[g0].sop, got_q[g0].eop, got_q[g0].empty); end
            compared++; if (got_q[g0+1].d !== 32'h00000605 || got_q[g0+1].sop !== 1'b0 || got_q[g0+1].eop !== 1'b1 || got_q[g0+1].empty !== 4'd8) begin
                mismatched++; $display("FAIL two_words_w1: got %h sop=%0b eop=%0b empty=%0d required 00000605 0 1 8", got_q[g0+1].d, got_q[g0+1].sop, got_q[g0+1].eop, got_q[g0+1].empty); end
            compared++; if (got_q[g0+1].cyc - got_q[g0].cyc != 2) begin
                mismatched++; $display("FAIL two_words_spacing: got %0d cycles required 2", got_q[g0+1].cyc - got_q[g0].cyc); end
        end
    endtask

    task automatic test_single_byte();
        beat_t bq[$];
        int    lc;
        int    g0 = got_q.size();
        bq.push_back(mk(8'hC6, 1, 1));
        drive_beats(bq, lc);
        wait_drain();
        compared++;
        if (got_q.size() - g0 != 1) begin
            mismatched++;
            $display("FAIL single_byte_count: got %0d words required 1", got_q.size() - g0);
        end else begin
            compared++; if (got_q[g0].d !== 32'h000000C6 || got_q[g0].sop !== 1'b1 || got_q[g0].eop !== 1'b1 || got_q[g0].empty !== 4'd12) begin
                mismatched++; $display("FAIL single_byte_word: got %h sop=%0b eop=%0b empty=%0d required 000000c6 1 1 12", got_q[g0].d, got_q[g0].sop, got_q[g0].eop, got_q[g0].empty); end
        end
    endtask

    task automatic test_backpressure();
        beat_t bq[$];
        int    lc;
        int    n  = 0;
        int    g0 = got_q.size();
        for (int i = 0; i < 8; i++) bq.push_back(mk(8'h10 + 8'(i), i == 0, i == 7));
        aso_out0_ready = 1'b0;
        fork
            drive_beats(bq, lc);
            begin
                while (!aso_out0_valid && n < 50) begin @(negedge clock_clk); n++; end
                if (!aso_out0_valid) begin
                    compared++; mismatched++;
                    $display("FAIL stall_no_word: got no output in 50 cycles required a word");
                end else begin
                    for (int j = 0; j < 3; j++) begin
                        if (j > 0) @(negedge clock_clk);
                        compared++; if (asi_in0_ready !== 1'b0) begin mismatched++; $display("FAIL stall_in_ready: cycle %0d got %0b required 0", j, asi_in0_ready); end
                        compared++; if (aso_out0_valid !== 1'b1 || aso_out0_data !== 32'h13121110) begin
                            mismatched++; $display("FAIL stall_hold: cycle %0d got valid=%0b data=%h required 1 13121110", j, aso_out0_valid, aso_out0_data); end
                    end
                end
                @(posedge clock_clk); #1;
                aso_out0_ready = 1'b1;
            end
        join
        wait_drain();
        compared++;
        if (got_q.size() - g0 != 2) begin
            mismatched++;
            $display("FAIL stall_count: got %0d words required 2", got_q.size() - g0);
        end else begin
            compared++; if (got_q[g0].d !== 32'h13121110 || got_q[g0+1].d !== 32'h17161514 || got_q[g0+1].eop !== 1'b1 || got_q[g0+1].empty !== 4'd0) begin
                mismatched++; $display("FAIL stall_words: got %h %h eop=%0b empty=%0d required 13121110 17161514 1 0", got_q[g0].d, got_q[g0+1].d, got_q[g0+1].eop, got_q[g0+1].empty); end
        end
    endtask

    task automatic test_framing();
        beat_t bq[$];
        int    lc;
        int    g0 = got_q.size();
        int    e0 = err_seen;
        bq.push_back(mk(8'hAA, 1, 0));
        bq.push_back(mk(8'hBB, 0, 0));
        bq.push_back(mk(8'h11, 1, 0));
        bq.push_back(mk(8'h22, 0, 0));
        bq.push_back(mk(8'h33, 0, 0));
        bq.push_back(mk(8'h44, 0, 1));
        drive_beats(bq, lc);
        wait_drain();
        compared++; if (err_seen - e0 != 1) begin mismatched++; $display("FAIL framing_sop_error: got %0d pulses required 1", err_seen - e0); end
        compared++;
        if (got_q.size() - g0 != 1) begin
            mismatched++; $display("FAIL framing_count: got %0d words required 1", got_q.size() - g0);
        end else if (got_q[g0].d !== 32'h44332211 || got_q[g0].sop !== 1'b1 || got_q[g0].eop !== 1'b1) begin
            mismatched++; $display("FAIL framing_word: got %h sop=%0b eop=%0b required 44332211 1 1", got_q[g0].d, got_q[g0].sop, got_q[g0].eop);
        end
        bq.delete();
        bq.push_back(mk(8'h77, 0, 0));
        g0 = got_q.size();
        e0 = err_seen;
        drive_beats(bq, lc);
        wait_drain();
        compared++; if (err_seen - e0 != 1 || got_q.size() != g0) begin
            mismatched++; $display("FAIL idle_stray: got %0d pulses %0d words required 1 pulse 0 words", err_seen - e0, got_q.size() - g0); end
    endtask

    task automatic test_reset_mid_packet();
        beat_t bq[$];
        int    lc;
        int    g0 = got_q.size();
        int    e0 = err_seen;
        bq.push_back(mk(8'h5A, 1, 0));
        bq.push_back(mk(8'h5B, 0, 0));
        drive_beats(bq, lc);
        reset_reset = 1'b1;
        @(posedge clock_clk); #1;
        reset_reset = 1'b0;
        @(negedge clock_clk);
        compared++; if (aso_out0_valid !== 1'b0 || aso_out0_data !== 32'h0 || aso_out0_empty !== 4'h0 || pkt_error !== 1'b0) begin
            mismatched++; $display("FAIL midreset_outputs: got valid=%0b data=%h empty=%0d err=%0b required all 0", aso_out0_valid, aso_out0_data, aso_out0_empty, pkt_error); end
        @(posedge clock_clk); #1;
        bq.delete();
        bq.push_back(mk(8'h0A, 1, 0));
        bq.push_back(mk(8'h0B, 0, 0));
        bq.push_back(mk(8'h0C, 0, 1));
        drive_beats(bq, lc);
        wait_drain();
        compared++;
        if (got_q.size() - g0 != 1 || err_seen != e0) begin
            mismatched++; $display("FAIL midreset_after: got %0d words %0d pulses required 1 word 0 pulses", got_q.size() - g0, err_seen - e0);
        end else if (got_q[g0].d !== 32'h000C0B0A || got_q[g0].empty !== 4'd4 || got_q[g0].sop !== 1'b1) begin
            mismatched++; $display("FAIL midreset_word: got %h empty=%0d sop=%0b required 000c0b0a 4 1", got_q[g0].d, got_q[g0].empty, got_q[g0].sop);
        end
    endtask

    task automatic test_random();
        beat_t bq[$];
        word_t exp_q[$];
        int    exp_err;
        int    lc;
        int    bad  = 0;
        bit    done = 0;
        int    g0   = got_q.size();
        int    e0   = err_seen;
        for (int p = 0; p < 40; p++) begin
            int len = $urandom_range(12, 1);
            if ($urandom_range(9) == 0) bq.push_back(mk(8'($urandom), 0, 0));
            for (int i = 0; i < len; i++)
                bq.push_back(mk(8'($urandom), i == 0, (i == len - 1) && ($urandom_range(7) != 0)));
        end
        bq.push_back(mk(8'h99, 1, 1));
        build_expected(bq, exp_q, exp_err);
        fork
            begin drive_beats(bq, lc); done = 1; end
            begin
                while (!done) begin
                    @(posedge clock_clk); #1;
                    aso_out0_ready = ($urandom_range(3) != 0);
                end
                aso_out0_ready = 1'b1;
            end
        join
        wait_drain();
        compared++; if (err_seen - e0 != exp_err) begin mismatched++; $display("FAIL random_errors: got %0d pulses required %0d", err_seen - e0, exp_err); end
        compared++;
        if (got_q.size() - g0 != exp_q.size()) begin
            mismatched++; $display("FAIL random_count: got %0d words required %0d", got_q.size() - g0, exp_q.size());
        end else begin
            foreach (exp_q[i]) begin
                word_t g = got_q[g0 + i];
                if (g.d !== exp_q[i].d || g.sop !== exp_q[i].sop || g.eop !== exp_q[i].eop || g.empty !== exp_q[i].empty) bad++;
                if (bad == 1 && (g.d !== exp_q[i].d || g.sop !== exp_q[i].sop || g.eop !== exp_q[i].eop || g.empty !== exp_q[i].empty))
                    $display("FAIL random_word %0d: got %h %0b %0b %0d required %h %0b %0b %0d", i, g.d, g.sop, g.eop, g.empty,
                             exp_q[i].d, exp_q[i].sop, exp_q[i].eop, exp_q[i].empty);
            end
            compared++; if (bad != 0) begin mismatched++; $display("FAIL random_words: %0d of %0d words differ, required 0", bad, exp_q.size()); end
        end
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_two_words();
        test_single_byte();
        test_backpressure();
        test_framing();
        test_reset_mid_packet();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

`default_nettype wire
